// File: rtl/esfa_pkg.sv
// Shared types and default constants for the ESFA run sequencer.
package esfa_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      RUN,
      SAMPLE,
      GAP,
      DONE
   } esfa_seq_state_t;

   localparam int ESFA_TIMEOUT_CYCLES = 20000;
   localparam int ESFA_GAP_CYCLES     = 2;

endpackage

// File: rtl/esfa_sat_accum.sv
// Saturating adder-accumulator: sum holds at all-ones once the true total no longer fits.
module esfa_sat_accum #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] addend,
   output logic [W-1:0] sum
);

   logic [W:0] raw;

   assign raw = {1'b0, sum} + {1'b0, addend};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum <= '0;
      end else if (clr) begin
         sum <= '0;
      end else if (en) begin
         sum <= raw[W] ? '1 : raw[W-1:0];
      end
   end

endmodule

// File: rtl/esfa_run_sequencer.sv
// Drives batches of back-to-back ESFA runs, timing each run in clock cycles and
// keeping pass/fail/timeout statistics for host readout.
module esfa_run_sequencer
   import esfa_pkg::*;
#(
   parameter int RUN_CNT_W      = 16,
   parameter int CYCLE_W        = 32,
   parameter int TIMEOUT_CYCLES = ESFA_TIMEOUT_CYCLES,
   parameter int GAP_CYCLES     = ESFA_GAP_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [RUN_CNT_W-1:0] numRuns,
   output logic                 doRun,
   input  logic                 isRunning,
   input  logic                 wasSuccessful,
   output logic                 busy,
   output logic                 done,
   output logic [RUN_CNT_W-1:0] passCount,
   output logic [RUN_CNT_W-1:0] failCount,
   output logic                 timedOut,
   output logic [CYCLE_W-1:0]   lastCycles,
   output logic [CYCLE_W-1:0]   maxCycles,
   output logic [CYCLE_W-1:0]   totalCycles,
   output esfa_seq_state_t      state
);

   localparam int                 GAP_W       = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
   localparam logic [CYCLE_W-1:0] TIMEOUT_VAL = CYCLE_W'(TIMEOUT_CYCLES);

   esfa_seq_state_t        state_q, next_state;
   logic [CYCLE_W-1:0]     count_q;
   logic [GAP_W-1:0]       gap_q;
   logic [RUN_CNT_W-1:0]   remaining_q;
   logic                   succ_q;
   logic                   accept;
   logic                   rec_timeout;
   logic                   at_limit;

   assign state    = state_q;
   assign at_limit = (count_q == TIMEOUT_VAL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= next_state;
   end

   always_comb begin
      next_state  = state_q;
      accept      = 1'b0;
      rec_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = (numRuns == '0) ? DONE : ARM;
            end
         end
         ARM: begin
            if (isRunning) begin
               next_state = RUN;
            end else if (at_limit) begin
               rec_timeout = 1'b1;
               next_state  = GAP;
            end
         end
         RUN: begin
            if (!isRunning) begin
               next_state = SAMPLE;
            end else if (at_limit) begin
               rec_timeout = 1'b1;
               next_state  = GAP;
            end
         end
         SAMPLE: next_state = GAP;
         GAP: begin
            if (gap_q == GAP_LAST && !isRunning)
               next_state = (remaining_q != '0) ? ARM : DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // doRun lags the state by one register, so the counter only advances once
   // doRun is actually high; that makes the first doRun-high cycle index 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         gap_q   <= '0;
         succ_q  <= 1'b0;
      end else begin
         if (next_state == ARM && state_q != ARM)
            count_q <= '0;
         else if ((state_q == ARM || state_q == RUN) &&
                  (next_state == ARM || next_state == RUN) && doRun)
            count_q <= count_q + CYCLE_W'(1);

         if (state_q != GAP)       gap_q <= '0;
         else if (gap_q != GAP_LAST) gap_q <= gap_q + GAP_W'(1);

         if (state_q == RUN && !isRunning) succ_q <= wasSuccessful;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         doRun       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timedOut    <= 1'b0;
         passCount   <= '0;
         failCount   <= '0;
         lastCycles  <= '0;
         maxCycles   <= '0;
         remaining_q <= '0;
      end else begin
         doRun <= (state_q == ARM) || (state_q == RUN) || (state_q == SAMPLE);
         done  <= (state_q == DONE);

         if (accept)                busy <= 1'b1;
         else if (state_q == DONE)  busy <= 1'b0;

         if (accept) begin
            remaining_q <= numRuns;
            timedOut    <= 1'b0;
            passCount   <= '0;
            failCount   <= '0;
            lastCycles  <= '0;
            maxCycles   <= '0;
         end else if (rec_timeout) begin
            failCount   <= failCount + RUN_CNT_W'(1);
            timedOut    <= 1'b1;
            remaining_q <= remaining_q - RUN_CNT_W'(1);
         end else if (state_q == SAMPLE) begin
            lastCycles  <= count_q;
            if (count_q > maxCycles) maxCycles <= count_q;
            if (succ_q) passCount <= passCount + RUN_CNT_W'(1);
            else        failCount <= failCount + RUN_CNT_W'(1);
            remaining_q <= remaining_q - RUN_CNT_W'(1);
         end
      end
   end

   esfa_sat_accum #(
      .W (CYCLE_W)
   ) u_total (
      .clk    (clk),
      .reset  (reset),
      .clr    (accept),
      .en     (state_q == SAMPLE),
      .addend (count_q),
      .sum    (totalCycles)
   );

endmodule

// File: doc/esfa_run_sequencer.md
# esfa_run_sequencer

Hardware run sequencer that sits directly upstream of `ESFATop`. It owns that block's `doRun` input and consumes its `isRunning`/`wasSuccessful` outputs. It executes a batch of N back-to-back ESFA runs and measures per-run latency in clock cycles, so benchmarking moves from the testbench into synthesizable logic. It also reports pass, fail and timeout statistics for readout by a host or debug bus.

## Interface
Parameters:
- `RUN_CNT_W`, 16: width of the run-count request and the pass/fail counters.
- `CYCLE_W`, 32: width of all cycle measurements.
- `TIMEOUT_CYCLES`, 20000: maximum cycles from `doRun` rising to run completion before the run is declared failed.
- `GAP_CYCLES`, 2: minimum cycles `doRun` is held low between consecutive runs (≥1).

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a batch when sampled high in IDLE; ignored otherwise.
- `numRuns`, in, RUN_CNT_W: number of runs, sampled on `start` acceptance.
- `doRun`, out, 1: drives `ESFATop.doRun`.
- `isRunning`, in, 1: from `ESFATop`.
- `wasSuccessful`, in, 1: from `ESFATop`; valid on the cycle `isRunning` is first seen low.
- `busy`, out, 1: high from `start` acceptance until `done`.
- `done`, out, 1: one-cycle pulse at batch end.
- `passCount`, out, RUN_CNT_W: completed runs with `wasSuccessful` = 1.
- `failCount`, out, RUN_CNT_W: runs with `wasSuccessful` = 0 or timed out.
- `timedOut`, out, 1: sticky; set if any run in the batch hit `TIMEOUT_CYCLES`.
- `lastCycles`, out, CYCLE_W: latency of the most recent completed run.
- `maxCycles`, out, CYCLE_W: largest `lastCycles` in the batch.
- `totalCycles`, out, CYCLE_W: sum of run latencies; saturates at all-ones.

## Operation
- States: IDLE, ARM, RUN, SAMPLE, GAP, DONE.
- IDLE: `doRun` = 0. On `start`:
  - latch `numRuns` and clear all statistics and `timedOut`.
  - If `numRuns` = 0, go to DONE. Otherwise go to ARM and clear the cycle counter.
- ARM: `doRun` = 1; counter increments each cycle.
  - When `isRunning` is sampled 1, go to RUN.
  - When the counter reaches `TIMEOUT_CYCLES`, record a timeout.
- RUN: `doRun` = 1; counter increments each cycle.
  - When `isRunning` is sampled 0, go to SAMPLE.
  - When the counter reaches `TIMEOUT_CYCLES`, record a timeout.
- Recording a timeout: increment `failCount`, set `timedOut`, decrement remaining runs, go to GAP. `lastCycles`, `maxCycles` and `totalCycles` are not updated.
- SAMPLE (one cycle): `doRun` = 1.
  - `lastCycles` ← counter. `maxCycles` ← max(`maxCycles`, counter). `totalCycles` ← saturating sum.
  - Increment `passCount` or `failCount` from `wasSuccessful`, which is captured on the RUN→SAMPLE edge.
  - Decrement remaining runs, then go to GAP.
- GAP: `doRun` = 0. Stay at least `GAP_CYCLES` cycles and until `isRunning` is sampled 0. Then go to ARM if runs remain (clear the counter), else to DONE.
- DONE (one cycle): `done` = 1, `busy` = 0 on the next cycle; return to IDLE.
- Statistics hold their values in IDLE until the next accepted `start`.
- `start` during a batch is ignored; there is no abort other than `reset`.

## Timing
- Reset (async assert, sync deassert expected from the reset tree): state = IDLE, and all outputs are 0: `doRun`, `busy`, `done`, `timedOut`, all counts and cycle fields.
- Reset mid-run drops `doRun` immediately; the batch is lost.
- `start` accepted at edge t: `busy` = 1 and state = ARM after t. `doRun` rises at t+1, registered.
- Latency definition: `doRun` first high in cycle 0. `lastCycles` = index of the cycle in which `isRunning` is first sampled low after having been high.
- `doRun` is a registered output; it never glitches.
- Counter width is CYCLE_W. `TIMEOUT_CYCLES` < 2^CYCLE_W, so the counter itself never wraps.
- `numRuns` = 0: `done` pulses two edges after `start`, and all statistics are 0.

## Structure
- Shared package `esfa_pkg`: state enum `esfa_seq_state_t` and default constants `ESFA_TIMEOUT_CYCLES` and `ESFA_GAP_CYCLES`.
- Sub-module `esfa_sat_accum`: a parameterized saturating adder-accumulator with clear and enable, used for `totalCycles`.
- Everything else (FSM, run counter, max tracker) lives in `esfa_run_sequencer`.

## Test plan
- `reset` low for 15 cycles, then high → all outputs 0, `doRun` = 0, state IDLE.
- `start`, `numRuns` = 1, model raises `isRunning` in cycle 2 and drops it in cycle 12 with `wasSuccessful` = 1 → `lastCycles` = 12, `maxCycles` = 12, `totalCycles` = 12, `passCount` = 1, `done` pulses once.
- `numRuns` = 3, latencies 12/30/8, success 1/0/1 → `passCount` = 2, `failCount` = 1, `maxCycles` = 30, `totalCycles` = 50, and `doRun` low ≥2 cycles between runs.
- `numRuns` = 2 with `TIMEOUT_CYCLES` = 100, first run never asserts `isRunning`:
  - first run times out at count 100 → `timedOut` = 1, `failCount` = 1.
  - second run completes normally.
- `numRuns` = 0 → `done` two edges after `start`, all counts 0; `start` pulsed while busy has no effect.
- `reset` asserted while in RUN → `doRun` = 0 immediately, all statistics 0; a subsequent `start` runs cleanly.
